// File: rtl/i2c_regfile.sv
// i2c_regfile: I2C-addressable 2^LD_NBYTES x 8 register file with an
// auto-incrementing 1- or 2-byte register pointer and a fabric-side port.
// i2c_slave: bit-level I2C target front end used by i2c_regfile.
// Optional macro I2C_REGFILE_WP_EN adds the wp input (I2C write protect).

module i2c_slave #(
  parameter int unsigned US       = 100,
  parameter logic [6:0]  SLV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       sda_out,
  input  logic [7:0] dat_in,
  output logic [7:0] dat_out,
  output logic       as_out,
  output logic       ws_out,
  output logic       rs_out
);
  // Spike filter length: roughly 50 ns worth of clock cycles, at least one.
  localparam int unsigned FILT = ((US / 20) > 0) ? (US / 20) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_AACK, S_WR, S_WACK, S_RD, S_RACK
  } sstate_t;

  sstate_t     state_q, state_d;
  logic [1:0]  sync0, sync1, filt, filt_d1;  // bit 1 = SCL, bit 0 = SDA
  logic [15:0] fcnt [2];
  logic [7:0]  sr_q, sr_d, dat_q, dat_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sda_q, sda_d, rw_q, rw_d, nack_q, nack_d;
  logic        as_q, as_d, ws_q, ws_d, rs_q, rs_d;
  logic        scl_rise, scl_fall, start_c, stop_c;

  // Synchronise the pads and accept a new level only after it is stable for FILT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0   <= '1;
      sync1   <= '1;
      filt    <= '1;
      filt_d1 <= '1;
      for (int unsigned i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync0   <= {scl_in, sda_in};
      sync1   <= sync0;
      filt_d1 <= filt;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync1[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == 16'(FILT - 1)) begin
          filt[i] <= sync1[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 16'd1;
        end
      end
    end
  end

  assign scl_rise = filt[1] & ~filt_d1[1];
  assign scl_fall = ~filt[1] & filt_d1[1];
  assign start_c  = filt[1] & filt_d1[1] & filt_d1[0] & ~filt[0];
  assign stop_c   = filt[1] & filt_d1[1] & ~filt_d1[0] & filt[0];

  // Protocol state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
      sda_q   <= 1'b1;
      rw_q    <= 1'b0;
      nack_q  <= 1'b0;
      as_q    <= 1'b0;
      ws_q    <= 1'b0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      sda_q   <= sda_d;
      rw_q    <= rw_d;
      nack_q  <= nack_d;
      as_q    <= as_d;
      ws_q    <= ws_d;
      rs_q    <= rs_d;
    end
  end

  // Next-state: SDA only ever changes after a detected SCL fall, so the
  // target never creates a false START/STOP on the bus.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    sda_d   = sda_q;
    rw_d    = rw_q;
    nack_d  = nack_q;
    as_d    = 1'b0;
    ws_d    = 1'b0;
    rs_d    = 1'b0;
    if (start_c) begin
      state_d = S_ADDR;
      cnt_d   = '0;
      sda_d   = 1'b1;
    end else if (stop_c) begin
      state_d = S_IDLE;
      sda_d   = 1'b1;
    end else begin
      case (state_q)
        S_ADDR, S_WR: begin
          if (scl_rise) begin
            sr_d  = {sr_q[6:0], filt[0]};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (state_q == S_WR) begin
              dat_d   = sr_q;
              ws_d    = 1'b1;
              sda_d   = 1'b0;
              state_d = S_WACK;
            end else if (sr_q[7:1] == SLV_ADDR) begin
              rw_d    = sr_q[0];
              as_d    = 1'b1;
              sda_d   = 1'b0;
              state_d = S_AACK;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_AACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (rw_q) begin
              sr_d    = dat_in;
              sda_d   = dat_in[7];
              state_d = S_RD;
            end else begin
              sda_d   = 1'b1;
              state_d = S_WR;
            end
          end
        end
        S_WACK: begin
          if (scl_fall) begin
            sda_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_WR;
          end
        end
        S_RD: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_d   = 1'b1;
              rs_d    = 1'b1;
              state_d = S_RACK;
            end else begin
              sr_d  = {sr_q[6:0], 1'b0};
              sda_d = sr_q[6];
            end
          end
        end
        S_RACK: begin
          if (scl_rise) begin
            nack_d = filt[0];
          end else if (scl_fall) begin
            if (nack_q) begin
              state_d = S_IDLE;
            end else begin
              sr_d    = dat_in;
              sda_d   = dat_in[7];
              cnt_d   = '0;
              state_d = S_RD;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_out = sda_q;
  assign dat_out = dat_q;
  assign as_out  = as_q;
  assign ws_out  = ws_q;
  assign rs_out  = rs_q;
endmodule

module i2c_regfile #(
  parameter int unsigned US        = 100,
  parameter int unsigned LD_NBYTES = 3,
  parameter int unsigned PTR_BYTES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sda_i,
  output logic                 sda_o,
  output logic                 sda_t,
  input  logic                 scl_i,
  output logic                 scl_o,
  output logic                 scl_t,
  input  logic [LD_NBYTES-1:0] usr_addr,
  input  logic                 usr_we,
  input  logic [7:0]           usr_wdat,
  output logic [7:0]           usr_rdat,
  output logic                 i2c_wr_stb,
  output logic [LD_NBYTES-1:0] i2c_wr_addr
`ifdef I2C_REGFILE_WP_EN
  ,
  input  logic                 wp
`endif
);
  localparam int unsigned DEPTH = 1 << LD_NBYTES;

  typedef enum logic [1:0] {IDLE, PTR_HI, PTR_LO, DATA} state_t;

  state_t               state_q, state_d;
  logic [7:0]           mem [DEPTH];
  logic [LD_NBYTES-1:0] ptr_q, ptr_d, ptr_load;
  logic [7:0]           hi_q, hi_d;
  logic [7:0]           dat_in, dat_out;
  logic                 as_out, ws_out, rs_out;
  logic                 wr_req, wr_do, wp_blk, coll;

  i2c_slave #(.US(US)) u_slave (
    .clk     (clk),
    .rst     (rst),
    .sda_in  (sda_i),
    .scl_in  (scl_i),
    .sda_out (sda_t),
    .dat_in  (dat_in),
    .dat_out (dat_out),
    .as_out  (as_out),
    .ws_out  (ws_out),
    .rs_out  (rs_out)
  );

  assign sda_o = 1'b0;
  assign scl_o = 1'b0;
  assign scl_t = 1'b1;

`ifdef I2C_REGFILE_WP_EN
  assign wp_blk = wp;
`else
  assign wp_blk = 1'b0;
`endif

  // Big-endian pointer bytes; high bits beyond the array depth are discarded.
  assign ptr_load = (PTR_BYTES == 2) ? LD_NBYTES'({hi_q, dat_out})
                                     : LD_NBYTES'({8'h00, dat_out});
  assign dat_in   = mem[ptr_q];
  assign wr_req   = ws_out & ((state_q == DATA) | (state_q == IDLE));
  assign coll     = usr_we & (usr_addr == ptr_q);
  // A blocked byte (fabric collision or write protect) still advances the pointer.
  assign wr_do    = wr_req & ~coll & ~wp_blk;

  // Control registers and the registered fabric read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hi_q        <= '0;
      usr_rdat    <= '0;
      i2c_wr_stb  <= 1'b0;
      i2c_wr_addr <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hi_q       <= hi_d;
      usr_rdat   <= mem[usr_addr];
      i2c_wr_stb <= wr_do;
      if (wr_do) i2c_wr_addr <= ptr_q;
    end
  end

  // Pointer-load sequencing driven by the slave strobes.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hi_d    = hi_q;
    if (as_out) begin
      state_d = (PTR_BYTES == 2) ? PTR_HI : PTR_LO;
      hi_d    = '0;
    end else if (rs_out) begin
      ptr_d   = ptr_q + LD_NBYTES'(1);
      hi_d    = '0;
      state_d = DATA;
    end else if (ws_out) begin
      case (state_q)
        PTR_HI: begin
          hi_d    = dat_out;
          state_d = PTR_LO;
        end
        PTR_LO: begin
          ptr_d   = ptr_load;
          state_d = DATA;
        end
        default: ptr_d = ptr_q + LD_NBYTES'(1);
      endcase
    end
  end

  // Array storage, not reset; fabric wins a same-address collision via wr_do.
  always_ff @(posedge clk) begin
    if (wr_do) mem[ptr_q] <= dat_out;
    if (usr_we) mem[usr_addr] <= usr_wdat;
  end
endmodule

// File: tb/tb_i2c_regfile.sv
// Directed bench for i2c_regfile: a bit-banged I2C master drives two instances
// (LD_NBYTES=3/PTR_BYTES=1 and LD_NBYTES=4/PTR_BYTES=2) on separate SDA lines.
`timescale 1ns/1ps
module tb_i2c_regfile;
  localparam int Q = 10;  // quarter SCL period in clk cycles
  localparam logic [7:0] AW = 8'hA0;
  localparam logic [7:0] AR = 8'hA1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic scl_m;
  logic sda_m [2];
  int   bsel;

  logic       sda_o0, sda_t0, scl_o0, scl_t0, sda_l0, scl_l0;
  logic       sda_o1, sda_t1, scl_o1, scl_t1, sda_l1, scl_l1;
  logic [2:0] ua0, wa0;
  logic [3:0] ua1, wa1;
  logic       uwe0, uwe1, stb0, stb1, wp0, wp1;
  logic [7:0] ud0, ud1, rd0, rd1;
  logic       bline;

  assign sda_l0 = sda_m[0] & (sda_t0 | sda_o0);
  assign scl_l0 = scl_m & (scl_t0 | scl_o0);
  assign sda_l1 = sda_m[1] & (sda_t1 | sda_o1);
  assign scl_l1 = scl_m & (scl_t1 | scl_o1);
  assign bline  = (bsel == 0) ? sda_l0 : sda_l1;

  i2c_regfile #(.US(10), .LD_NBYTES(3), .PTR_BYTES(1)) dut0 (
    .clk(clk), .rst(rst), .sda_i(sda_l0), .sda_o(sda_o0), .sda_t(sda_t0),
    .scl_i(scl_l0), .scl_o(scl_o0), .scl_t(scl_t0),
    .usr_addr(ua0), .usr_we(uwe0), .usr_wdat(ud0), .usr_rdat(rd0),
    .i2c_wr_stb(stb0), .i2c_wr_addr(wa0)
`ifdef I2C_REGFILE_WP_EN
    , .wp(wp0)
`endif
  );

  i2c_regfile #(.US(10), .LD_NBYTES(4), .PTR_BYTES(2)) dut1 (
    .clk(clk), .rst(rst), .sda_i(sda_l1), .sda_o(sda_o1), .sda_t(sda_t1),
    .scl_i(scl_l1), .scl_o(scl_o1), .scl_t(scl_t1),
    .usr_addr(ua1), .usr_we(uwe1), .usr_wdat(ud1), .usr_rdat(rd1),
    .i2c_wr_stb(stb1), .i2c_wr_addr(wa1)
`ifdef I2C_REGFILE_WP_EN
    , .wp(wp1)
`endif
  );

  logic [3:0] stbq0 [$];
  logic [3:0] stbq1 [$];
  always @(negedge clk) begin
    if (stb0) stbq0.push_back({1'b0, wa0});
    if (stb1) stbq1.push_back(wa1);
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m[bsel] = 1'b1; tick(Q);
    scl_m = 1'b1;       tick(Q);
    sda_m[bsel] = 1'b0; tick(Q);
    scl_m = 1'b0;       tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m[bsel] = 1'b0; tick(Q);
    scl_m = 1'b1;       tick(Q);
    sda_m[bsel] = 1'b1; tick(Q);
  endtask

  task automatic wbit(logic b);
    sda_m[bsel] = b; tick(Q);
    scl_m = 1'b1;    tick(2 * Q);
    scl_m = 1'b0;    tick(Q);
  endtask

  task automatic rbit(output logic b);
    sda_m[bsel] = 1'b1; tick(Q);
    scl_m = 1'b1;       tick(Q);
    b = bline;          tick(Q);
    scl_m = 1'b0;       tick(Q);
  endtask

  task automatic wbyte(string tag, logic [7:0] d);
    logic nb;
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(nb);
    check(tag, {15'd0, nb}, 16'd0);
  endtask

  task automatic rbyte(output logic [7:0] d, input logic nack);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      rbit(b);
      d = {d[6:0], b};
    end
    wbit(nack);
  endtask

  // Write transaction: address byte then n bytes (pointer and data).
  task automatic i2c_wr(int s, int n, logic [7:0] bs [4]);
    bsel = s;
    i2c_start();
    wbyte("ack_aw", AW);
    for (int i = 0; i < n; i++) wbyte("ack_wr", bs[i]);
    i2c_stop();
  endtask

  // Optional pointer write, then (repeated) start and up to two read bytes.
  task automatic i2c_rd(int s, int np, logic [7:0] p0, logic [7:0] p1, int nr,
                        output logic [7:0] r0, output logic [7:0] r1);
    bsel = s;
    r1 = '0;
    i2c_start();
    if (np > 0) begin
      wbyte("ack_aw", AW);
      wbyte("ack_p0", p0);
      if (np > 1) wbyte("ack_p1", p1);
      i2c_start();
    end
    wbyte("ack_ar", AR);
    rbyte(r0, nr == 1);
    if (nr > 1) rbyte(r1, 1'b1);
    i2c_stop();
  endtask

  task automatic usr_wr(int s, logic [3:0] a, logic [7:0] d);
    @(negedge clk);
    if (s == 0) begin ua0 = a[2:0]; ud0 = d; uwe0 = 1'b1; end
    else        begin ua1 = a;      ud1 = d; uwe1 = 1'b1; end
    @(negedge clk);
    uwe0 = 1'b0;
    uwe1 = 1'b0;
  endtask

  task automatic usr_rd(int s, logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    if (s == 0) ua0 = a[2:0]; else ua1 = a;
    @(negedge clk);
    d = (s == 0) ? rd0 : rd1;
  endtask

  logic [7:0] r0, r1;

  initial begin
    rst = 1'b1; scl_m = 1'b1; sda_m[0] = 1'b1; sda_m[1] = 1'b1; bsel = 0;
    ua0 = '0; ua1 = '0; uwe0 = 1'b0; uwe1 = 1'b0; ud0 = '0; ud1 = '0;
    wp0 = 1'b0; wp1 = 1'b0;
    tick(5);
    check("rst_rdat0", {8'd0, rd0}, 16'h0000);
    check("rst_rdat1", {8'd0, rd1}, 16'h0000);
    check("rst_stb0", {15'd0, stb0}, 16'd0);
    check("rst_waddr0", {13'd0, wa0}, 16'd0);
    check("rst_sda_t0", {15'd0, sda_t0}, 16'd1);
    check("rst_pins0", {13'd0, scl_t0, sda_o0, scl_o0}, 16'b100);
    rst = 1'b0;
    tick(5);

    // Pointer 6, three bytes wrapping 7 -> 0.
    i2c_wr(0, 4, '{8'h06, 8'hA1, 8'hB2, 8'hC3});
    check("t1_nstb", 16'(stbq0.size()), 16'd3);
    if (stbq0.size() == 3) begin
      check("t1_stb_a0", {12'd0, stbq0[0]}, 16'd6);
      check("t1_stb_a1", {12'd0, stbq0[1]}, 16'd7);
      check("t1_stb_a2", {12'd0, stbq0[2]}, 16'd0);
    end
    stbq0.delete();
    usr_rd(0, 4'd6, r0); check("t1_mem6", {8'd0, r0}, 16'h00A1);
    usr_rd(0, 4'd7, r0); check("t1_mem7", {8'd0, r0}, 16'h00B2);
    usr_rd(0, 4'd0, r0); check("t1_mem0", {8'd0, r0}, 16'h00C3);

    // Two-byte pointer 0x123C keeps low 4 bits -> 0xC.
    i2c_wr(1, 3, '{8'h12, 8'h3C, 8'h55, 8'h00});
    check("t2_nstb", 16'(stbq1.size()), 16'd1);
    if (stbq1.size() == 1) check("t2_stb_a", {12'd0, stbq1[0]}, 16'h000C);
    stbq1.delete();
    usr_wr(1, 4'hD, 8'h3D);
    i2c_rd(1, 2, 8'h00, 8'h0C, 2, r0, r1);
    check("t2_rd0", {8'd0, r0}, 16'h0055);
    check("t2_rd1", {8'd0, r1}, 16'h003D);

    // Fabric write visible to I2C read and fabric read.
    usr_wr(0, 4'd3, 8'h7E);
    i2c_rd(0, 1, 8'h03, 8'h00, 1, r0, r1);
    check("t3_i2c_rd", {8'd0, r0}, 16'h007E);
    usr_rd(0, 4'd3, r0); check("t3_usr_rd", {8'd0, r0}, 16'h007E);

    // Same-address collision: fabric wins, pointer still advances.
    bsel = 0;
    i2c_start();
    wbyte("ack_aw", AW);
    wbyte("ack_p", 8'h02);
    @(negedge clk); ua0 = 3'd2; ud0 = 8'h11; uwe0 = 1'b1;
    wbyte("ack_coll", 8'h22);
    @(negedge clk); uwe0 = 1'b0;
    wbyte("ack_d", 8'h33);
    i2c_stop();
    check("t4_nstb", 16'(stbq0.size()), 16'd1);
    if (stbq0.size() == 1) check("t4_stb_a", {12'd0, stbq0[0]}, 16'd3);
    stbq0.delete();
    usr_rd(0, 4'd2, r0); check("t4_mem2", {8'd0, r0}, 16'h0011);
    usr_rd(0, 4'd3, r0); check("t4_mem3", {8'd0, r0}, 16'h0033);

    // Reset after the pointer byte, before data.
    bsel = 0;
    i2c_start();
    wbyte("ack_aw", AW);
    wbyte("ack_p", 8'h05);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("t5_rst_sda_t", {15'd0, sda_t0}, 16'd1);
    rst = 1'b0;
    tick(3);
    i2c_stop();
    i2c_rd(0, 0, 8'h00, 8'h00, 1, r0, r1);
    check("t5_ptr0_rd", {8'd0, r0}, 16'h00C3);
    i2c_wr(0, 2, '{8'h01, 8'h99, 8'h00, 8'h00});
    check("t5_nstb", 16'(stbq0.size()), 16'd1);
    if (stbq0.size() == 1) check("t5_stb_a", {12'd0, stbq0[0]}, 16'd1);
    stbq0.delete();
    usr_rd(0, 4'd1, r0); check("t5_mem1", {8'd0, r0}, 16'h0099);
    usr_rd(0, 4'd6, r0); check("t5_mem6", {8'd0, r0}, 16'h00A1);

`ifdef I2C_REGFILE_WP_EN
    // Write protect drops the byte but advances the pointer.
    usr_wr(0, 4'd4, 8'h44);
    usr_wr(0, 4'd5, 8'h5A);
    wp0 = 1'b1;
    i2c_wr(0, 2, '{8'h04, 8'hEE, 8'h00, 8'h00});
    check("t6_wp_nstb", 16'(stbq0.size()), 16'd0);
    stbq0.delete();
    i2c_rd(0, 0, 8'h00, 8'h00, 1, r0, r1);
    check("t6_wp_ptr5", {8'd0, r0}, 16'h005A);
    usr_rd(0, 4'd4, r0); check("t6_wp_mem4", {8'd0, r0}, 16'h0044);
    wp0 = 1'b0;
    i2c_wr(0, 2, '{8'h04, 8'hEE, 8'h00, 8'h00});
    check("t6_nstb", 16'(stbq0.size()), 16'd1);
    if (stbq0.size() == 1) check("t6_stb_a", {12'd0, stbq0[0]}, 16'd4);
    stbq0.delete();
    usr_rd(0, 4'd4, r0); check("t6_mem4", {8'd0, r0}, 16'h00EE);
`endif

    check("end_nstb1", 16'(stbq1.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_regfile.md
# i2c_regfile

Parametrised I2C-addressable register file: an `i2c_slave` front end plus a 2^LD_NBYTES x 8 flop array with a 1- or 2-byte auto-incrementing register pointer. A second, fabric-side read/write port shares the array. An I2C write strobe tells local logic when the master has updated a register. It sits between the board I2C pads (via IOBUF tristates) and local control logic as the generic configuration/status register bank.

## Interface
- `US`, 100: clock cycles per microsecond; passed to `i2c_slave`.
- `LD_NBYTES`, 3: log2 of array depth; legal range 1..16.
- `PTR_BYTES`, 1: number of pointer bytes following the slave address, big-endian; legal values 1 or 2.

- `clk`  in  1  single clock; everything is synchronous to its rising edge.
- `rst`  in  1  synchronous, active-high reset; also drives the `i2c_slave` `rst`.
- `sda_i`  in  1  SDA pad input.
- `sda_o`  out  1  constant 0.
- `sda_t`  out  1  SDA tristate; 1 = released. Driven by `i2c_slave` `sda_out`.
- `scl_i`  in  1  SCL pad input.
- `scl_o`  out  1  constant 0.
- `scl_t`  out  1  constant 1; the block never stretches the clock.
- `usr_addr`  in  LD_NBYTES  fabric port address.
- `usr_we`  in  1  fabric write enable.
- `usr_wdat`  in  8  fabric write data.
- `usr_rdat`  out  8  registered `mem[usr_addr]`.
- `i2c_wr_stb`  out  1  one-cycle pulse when an I2C data byte is stored.
- `i2c_wr_addr`  out  LD_NBYTES  address of that stored byte; holds until the next strobe.
- `wp`  in  1  I2C write protect; present only with `I2C_REGFILE_WP_EN`.

## Operation
- Pointer `ptr` is LD_NBYTES wide.
- Loaded pointer bytes are concatenated big-endian. Only the low LD_NBYTES bits are kept; excess high bits are discarded.
- `i2c_slave` `dat_in` = `mem[ptr]`, combinational read.
- FSM states: IDLE, PTR_HI, PTR_LO, DATA.
  - `as_out` pulse, from any state: go to PTR_HI if PTR_BYTES=2, else PTR_LO.
  - `ws_out` in PTR_HI: load pointer high byte; go to PTR_LO.
  - `ws_out` in PTR_LO: load pointer low byte; go to DATA.
  - `ws_out` in DATA or IDLE: write `mem[ptr]` <= `dat_out`; pulse `i2c_wr_stb`; `i2c_wr_addr` <= `ptr`; `ptr` <= `ptr`+1.
  - `rs_out` in any state: `ptr` <= `ptr`+1; go to DATA. A read before the pointer is fully loaded abandons the load; any partially loaded high byte is discarded.
- Pointer increment wraps modulo 2^LD_NBYTES: DEPTH-1 -> 0.
- Fabric port:
  - `usr_we`=1 writes `mem[usr_addr]` <= `usr_wdat` on the same edge.
  - `usr_rdat` is updated every cycle from `mem[usr_addr]` as it was before that edge (read-before-write).
- Collision, I2C data write and `usr_we` in the same cycle:
  - Different addresses: both writes occur.
  - Same address: fabric wins. The I2C byte is dropped, `i2c_wr_stb` stays 0, and `ptr` still increments.
- `mem` is not reset; its contents survive `rst`.

## Timing
- Reset values: FSM IDLE, `ptr`=0, `usr_rdat`=0, `i2c_wr_stb`=0, `i2c_wr_addr`=0, `sda_t`=1.
- `rst` asserted mid-transfer: the slave and FSM return to IDLE on the next edge. The master sees NACK/released SDA. Any partial pointer load is discarded.
- `i2c_wr_stb` is asserted in the cycle after the `ws_out` pulse; `i2c_wr_addr` is valid in that same cycle.
- Fabric read latency: 1 cycle.
- An I2C write becomes visible on `usr_rdat` 2 cycles after `ws_out` (`usr_addr` held).
- A fabric write becomes visible on `dat_in` in the next cycle.
- Simultaneous `as_out` and `ws_out`/`rs_out` cannot occur (guaranteed by `i2c_slave`); no priority is defined.

## Configuration
- `I2C_REGFILE_WP_EN` defined:
  - Port `wp` exists.
  - While `wp`=1, I2C data writes are dropped: no `mem` update, no `i2c_wr_stb`, `ptr` still increments.
  - Pointer loads and I2C reads are unaffected; the slave still ACKs.
  - The fabric port ignores `wp`.
- Not defined: no `wp` port; I2C data writes always proceed, subject only to the collision rule.

## Test plan
- LD_NBYTES=3, PTR_BYTES=1; I2C write ptr 0x06 then data 0xA1, 0xB2, 0xC3 -> mem[6]=A1, mem[7]=B2, mem[0]=C3 (wrap); three `i2c_wr_stb` pulses with `i2c_wr_addr` 6, 7, 0.
- PTR_BYTES=2, LD_NBYTES=4; write ptr 0x12,0x3C then 0x55 -> mem[0xC]=0x55; repeated-start read of 2 bytes from ptr 0x000C -> returns 0x55 then mem[0xD].
- Fabric writes mem[3]=0x7E; I2C sets ptr=3 and reads 1 byte -> 0x7E; `usr_addr`=3 -> `usr_rdat`=0x7E one cycle later.
- Force `usr_we` with `usr_addr`=ptr=2 in the `ws_out` cycle, `usr_wdat`=0x11, I2C byte 0x22 -> mem[2]=0x11, no strobe, next I2C byte lands at 3.
- `rst` pulsed after the pointer byte but before data, then a new write of ptr 0x01, data 0x99 -> FSM restarts cleanly, mem[1]=0x99, earlier mem contents intact.
- With `I2C_REGFILE_WP_EN` and `wp`=1: I2C write ptr 4, data 0xEE -> mem[4] unchanged, no strobe, ptr=5; with `wp`=0 the same write stores 0xEE.
